serial_bus_master_port: RTL and testbench
=========================================

SERIAL_BUS_MASTER_PORT -- requirements
Module: serial_bus_master_port

Parameters
REQ-001 Parameters SHALL be (name, default, meaning): ADDRESS_WIDTH, 15, slave memory address bits.
REQ-002 DATA_WIDTH, 8, data word bits.
REQ-003 TIMEOUT, 63, maximum idle cycles spent waiting for a read response start bit.

Interface
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rstn  in  1  synchronous reset, active-high (rstn=1 resets at the next rising edge).
REQ-006 start  in  1  one-cycle transaction request; sampled only in IDLE.
REQ-007 rd_wrt_in  in  1  1 = write, 0 = read; latched with start.
REQ-008 slave_id  in  3  target slave ID; latched with start.
REQ-009 addr  in  ADDRESS_WIDTH  target address; latched with start.
REQ-010 wr_data  in  DATA_WIDTH  write word; latched with start.
REQ-011 bus_grant  in  1  arbiter grant, level.
REQ-012 bus_req  out  1  arbiter request.
REQ-013 rd_wrt  out  1  latched direction driven to slaves.
REQ-014 bus_util  out  1  active-low bus-in-use flag.
REQ-015 dout, dout_en  out  1, 1  serial data and tri-state enable for data_bus_serial; top level builds the pad.
REQ-016 din  in  1  serial bus value read back from the pad.
REQ-017 rd_data  out  DATA_WIDTH  last successfully read word.
REQ-018 done, err  out  1, 1  done is a one-cycle completion pulse; err is valid only while done=1.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 state  out  3  encoded FSM state: IDLE=0, REQ=1, SEND=2, RWAIT=3, RDATA=4, DONE=5.

Function
REQ-021 IDLE: on start=1, latch rd_wrt_in, slave_id, addr and wr_data, then go to REQ; start in any other state SHALL be ignored.
REQ-022 REQ: bus_req=1; on the first edge sampling bus_grant=1, go to SEND and assert bus_util=0 from that cycle.
REQ-023 SEND frame, one bit per cycle, dout_en=1: start bit 0, slave_id MSB-first, addr MSB-first, then wr_data MSB-first for writes only.
REQ-024 Frame length SHALL be 1+3+ADDRESS_WIDTH (19) bits for reads and 19+DATA_WIDTH (27) bits for writes; the bit counter SHALL be wide enough for 27 without wrap.
REQ-025 A write SHALL go to DONE on the cycle after its last frame bit.
REQ-026 A read SHALL go to RWAIT on the cycle after its last frame bit.
REQ-027 RWAIT: dout_en=0 and bus_util held 0; din=0 SHALL move to RDATA; reaching TIMEOUT cycles with din=1 SHALL go to DONE with err=1.
REQ-028 RDATA: shift 8 bits of din MSB-first, then go to DONE; rd_data SHALL update only on the DONE entry edge of a successful read.
REQ-029 DONE lasts exactly one cycle: done=1, bus_req=0, bus_util=1, dout_en=0, then return to IDLE.
REQ-030 If bus_grant falls during SEND, RWAIT or RDATA, the transaction SHALL abort: next state DONE, err=1, rd_data unchanged.
REQ-031 Write start-to-done latency with grant already high SHALL be 1 (REQ) + 27 + 1 = 29 cycles.
REQ-032 dout SHALL be 1 whenever dout_en=0.

Reset
REQ-033 On rstn=1, including mid-transaction, the next edge SHALL force state=IDLE, bus_req=0, bus_util=1, rd_wrt=0, dout=1, dout_en=0, done=0, err=0, busy=0, rd_data=0, and clear all latches and counters.
REQ-034 No partial frame bits SHALL be driven after reset.

Verification
REQ-035 Write: slave_id=3'd0, addr=15'h0005, wr_data=8'hA5, grant held high -> dout_en high for 27 cycles; bits 0,000,000000000000101,10100101; done at cycle 29; err=0.
REQ-036 Read: addr=15'h0005 with the bench replying 0 then 8'h6F after 4 RWAIT cycles -> rd_data=8'h6F, done=1, err=0, bus_util=0 throughout.
REQ-037 Read timeout: din held at 1 -> done with err=1 after 63 RWAIT cycles; rd_data keeps its prior value.
REQ-038 Grant delayed 10 cycles -> bus_req high and dout_en low for 10 cycles; frame starts the cycle grant is sampled high.
REQ-039 Grant dropped at SEND bit 12 -> next cycle done=1, err=1; then IDLE.
REQ-040 rstn asserted at SEND bit 5 -> next edge all outputs at reset values; a subsequent start runs a clean 29-cycle write.

Source files
------------

// File: rtl/serial_bus_master_port.sv
// Master port for a single-wire serial slave bus: arbitrates for the bus,
// shifts out {start, slave_id, addr[, wr_data]}, then waits for and captures a read reply.
//
// state | meaning
// IDLE  | waiting for start; request fields latched on start
// REQ   | bus_req high, waiting for bus_grant
// SEND  | frame driven on dout, one bit per cycle, MSB first
// RWAIT | read only: waiting for the slave's 0 start bit, bounded by TIMEOUT
// RDATA | read only: shifting DATA_WIDTH reply bits in from din
// DONE  | one-cycle completion pulse, err flags abort or timeout
module serial_bus_master_port #(
   parameter int ADDRESS_WIDTH = 15,
   parameter int DATA_WIDTH    = 8,
   parameter int TIMEOUT       = 63
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic                     rd_wrt_in,
   input  logic [2:0]               slave_id,
   input  logic [ADDRESS_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     bus_grant,
   output logic                     bus_req,
   output logic                     rd_wrt,
   output logic                     bus_util,
   output logic                     dout,
   output logic                     dout_en,
   input  logic                     din,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     done,
   output logic                     err,
   output logic                     busy,
   output logic [2:0]               state
);

   localparam int FRAME_W = 1 + 3 + ADDRESS_WIDTH + DATA_WIDTH;
   localparam int CNT_MAX = (FRAME_W > TIMEOUT) ? FRAME_W : TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] LAST_WR  = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] LAST_RD  = CNT_W'(FRAME_W - DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] RX_LOAD  = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_SEND  = 3'd2,
      ST_RWAIT = 3'd3,
      ST_RDATA = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   state_t                 state_q,   state_d;
   logic [FRAME_W-1:0]     frame_q,   frame_d;
   logic                   rd_wrt_q,  rd_wrt_d;
   logic [CNT_W-1:0]       cnt_q,     cnt_d;
   logic [DATA_WIDTH-1:0]  rx_q,      rx_d;
   logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
   logic                   err_q,     err_d;

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q   <= ST_IDLE;
         frame_q   <= '0;
         rd_wrt_q  <= 1'b0;
         cnt_q     <= '0;
         rx_q      <= '0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         rd_wrt_q  <= rd_wrt_d;
         cnt_q     <= cnt_d;
         rx_q      <= rx_d;
         rd_data_q <= rd_data_d;
         err_q     <= err_d;
      end
   end

   // Single down-counter reused as frame bit counter, reply timer and reply bit counter.
   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      rd_wrt_d  = rd_wrt_q;
      cnt_d     = cnt_q;
      rx_d      = rx_q;
      rd_data_d = rd_data_q;
      err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               frame_d  = {1'b0, slave_id, addr, wr_data};
               rd_wrt_d = rd_wrt_in;
               cnt_d    = '0;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus_grant) begin
               cnt_d   = rd_wrt_q ? LAST_WR : LAST_RD;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!bus_grant) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               frame_d = {frame_q[FRAME_W-2:0], 1'b0};
               if (cnt_q == '0) begin
                  if (rd_wrt_q) begin
                     state_d = ST_DONE;
                  end else begin
                     cnt_d   = TMO_LOAD;
                     state_d = ST_RWAIT;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         ST_RWAIT: begin
            if (!bus_grant) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (!din) begin
               cnt_d   = RX_LOAD;
               rx_d    = '0;
               state_d = ST_RDATA;
            end else if (cnt_q == '0) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_RDATA: begin
            if (!bus_grant) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               rx_d = {rx_q[DATA_WIDTH-2:0], din};
               if (cnt_q == '0) begin
                  rd_data_d = {rx_q[DATA_WIDTH-2:0], din};
                  state_d   = ST_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // bus_req stays up for the whole time the bus is owned and drops in DONE.
   assign bus_req  = (state_q == ST_REQ) || (state_q == ST_SEND) ||
                     (state_q == ST_RWAIT) || (state_q == ST_RDATA);
   assign bus_util = !((state_q == ST_SEND) || (state_q == ST_RWAIT) || (state_q == ST_RDATA));
   assign dout_en  = (state_q == ST_SEND);
   assign dout     = (state_q == ST_SEND) ? frame_q[FRAME_W-1] : 1'b1;
   assign rd_wrt   = rd_wrt_q;
   assign rd_data  = rd_data_q;
   assign done     = (state_q == ST_DONE);
   assign err      = err_q;
   assign busy     = (state_q != ST_IDLE);
   assign state    = state_q;

endmodule

// File: tb/tb_serial_bus_master_port.sv
// Self-checking bench for serial_bus_master_port: table of transactions with
// hand-derived latency/err/rd_data, a frame model, and a reset-mid-frame sequence.
module tb_serial_bus_master_port;
   localparam int AW = 15;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rstn, start, rd_wrt_in, bus_grant, din;
   logic [2:0] slave_id;
   logic [AW-1:0] addr;
   logic [DW-1:0] wr_data;
   logic bus_req, rd_wrt, bus_util, dout, dout_en, done, err, busy;
   logic [DW-1:0] rd_data;
   logic [2:0] state;

   always #5 clk = ~clk;

   serial_bus_master_port #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(63)) dut (
      .clk(clk), .rstn(rstn), .start(start), .rd_wrt_in(rd_wrt_in),
      .slave_id(slave_id), .addr(addr), .wr_data(wr_data), .bus_grant(bus_grant),
      .bus_req(bus_req), .rd_wrt(rd_wrt), .bus_util(bus_util), .dout(dout),
      .dout_en(dout_en), .din(din), .rd_data(rd_data), .done(done), .err(err),
      .busy(busy), .state(state)
   );

   typedef struct {
      logic          rw;
      logic [2:0]    sid;
      logic [AW-1:0] adr;
      logic [DW-1:0] wd;
      int            gd;
      int            wt;
      logic [DW-1:0] reply;
      bit            tmo;
      int            abort_at;
      bit            poke;
      int            exp_lat;
      bit            exp_err;
      logic [DW-1:0] exp_rd;
   } vec_t;

   typedef struct {
      int            lat;
      bit            err;
      logic [DW-1:0] rd;
      logic [26:0]   bits;
      int            len;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[9];
   int n_checks = 0;
   int n_fail = 0;

   function automatic vec_t mk(input logic rw, input logic [2:0] sid, input logic [AW-1:0] adr,
                               input logic [DW-1:0] wd, input int gd, input int wt,
                               input logic [DW-1:0] reply, input bit tmo, input int abort_at,
                               input bit poke, input int exp_lat, input bit exp_err,
                               input logic [DW-1:0] exp_rd);
      vec_t v;
      v.rw = rw; v.sid = sid; v.adr = adr; v.wd = wd; v.gd = gd; v.wt = wt;
      v.reply = reply; v.tmo = tmo; v.abort_at = abort_at; v.poke = poke;
      v.exp_lat = exp_lat; v.exp_err = exp_err; v.exp_rd = exp_rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_state"},    32'(state),    32'd0);
      chk({tag, "_bus_req"},  32'(bus_req),  32'd0);
      chk({tag, "_bus_util"}, 32'(bus_util), 32'd1);
      chk({tag, "_rd_wrt"},   32'(rd_wrt),   32'd0);
      chk({tag, "_dout"},     32'(dout),     32'd1);
      chk({tag, "_dout_en"},  32'(dout_en),  32'd0);
      chk({tag, "_done"},     32'(done),     32'd0);
      chk({tag, "_err"},      32'(err),      32'd0);
      chk({tag, "_busy"},     32'(busy),     32'd0);
      chk({tag, "_rd_data"},  32'(rd_data),  32'd0);
   endtask

   // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
   task automatic run_vec(input int idx, input vec_t v);
      int r, len, cap_exp, rw_idx, req_cnt, util_bad, idle_bad, busy_bad, err_bad, cap_len, n;
      bit seen_send, got_done;
      logic [26:0] cap, full;
      exp_t e, o;
      string p;
      p = $sformatf("v%0d", idx);
      r = (v.gd == 0) ? 1 : v.gd;
      len = v.rw ? 27 : 19;
      cap_exp = (v.abort_at >= 0 && v.abort_at + 1 < len) ? v.abort_at + 1 : len;
      full = {1'b0, v.sid, v.adr, v.wd};
      e.lat = v.exp_lat; e.err = v.exp_err; e.rd = v.exp_rd;
      e.len = cap_exp; e.bits = full >> (27 - cap_exp);
      sb_q.push_back(e);

      start = 1'b1; rd_wrt_in = v.rw; slave_id = v.sid; addr = v.adr; wr_data = v.wd;
      bus_grant = (v.gd == 0); din = 1'b1;
      req_cnt = 0; util_bad = 0; idle_bad = 0; busy_bad = 0; err_bad = 0; cap_len = 0;
      seen_send = 0; got_done = 0; cap = '0;

      for (n = 1; n <= v.exp_lat + 20 && !got_done; n++) begin
         @(negedge clk);
         start = (v.poke && n == 3);
         if (v.poke && n == 3) begin
            rd_wrt_in = ~v.rw; slave_id = ~v.sid; addr = ~v.adr; wr_data = ~v.wd;
         end
         if (dout_en === 1'b1) begin
            seen_send = 1;
            cap = {cap[25:0], dout};
            cap_len++;
         end else if (dout !== 1'b1) begin
            idle_bad++;
         end
         if (!seen_send && bus_req === 1'b1 && dout_en === 1'b0) req_cnt++;
         if (done === 1'b1) begin
            if (bus_util !== 1'b1) util_bad++;
         end else if (seen_send) begin
            if (bus_util !== 1'b0) util_bad++;
         end else if (bus_util !== 1'b1) begin
            util_bad++;
         end
         if (busy !== 1'b1) busy_bad++;
         if (done !== 1'b1 && err !== 1'b0) err_bad++;
         if (done === 1'b1) begin
            got_done = 1;
            o = sb_q.pop_front();
            chk({p, "_latency"},   32'(n),        32'(o.lat));
            chk({p, "_err"},       32'(err),      32'(o.err));
            chk({p, "_rd_data"},   32'(rd_data),  32'(o.rd));
            chk({p, "_frame_len"}, 32'(cap_len),  32'(o.len));
            chk({p, "_frame"},     32'(cap),      32'(o.bits));
            chk({p, "_bus_req"},   32'(bus_req),  32'd0);
            chk({p, "_rd_wrt"},    32'(rd_wrt),   32'(v.rw));
         end
         if (v.gd > 0 && n == v.gd) bus_grant = 1'b1;
         if (v.abort_at >= 0 && n == r + 1 + v.abort_at) bus_grant = 1'b0;
         rw_idx = n - (r + len + 1);
         din = 1'b1;
         if (!v.rw && !v.tmo && rw_idx >= v.wt) begin
            if (rw_idx == v.wt) din = 1'b0;
            else if (rw_idx <= v.wt + DW) din = v.reply[DW - 1 - (rw_idx - v.wt - 1)];
         end
      end
      if (!got_done) begin
         chk({p, "_done_seen"}, 32'd0, 32'd1);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
      chk({p, "_req_cycles"}, 32'(req_cnt),  32'(r));
      chk({p, "_bus_util"},   32'(util_bad), 32'd0);
      chk({p, "_dout_idle"},  32'(idle_bad), 32'd0);
      chk({p, "_busy"},       32'(busy_bad), 32'd0);
      chk({p, "_err_stray"},  32'(err_bad),  32'd0);
      start = 1'b0; bus_grant = 1'b1; din = 1'b1;
      @(negedge clk);
      chk({p, "_idle_after"}, 32'({busy, done, state}), 32'd0);
   endtask

   initial begin
      vecs[0] = mk(1, 3'd0, 15'h0005, 8'hA5, 0, 0, 8'h00, 0, -1, 0, 29, 0, 8'h00);
      vecs[1] = mk(0, 3'd2, 15'h0005, 8'h00, 0, 4, 8'h6F, 0, -1, 0, 34, 0, 8'h6F);
      vecs[2] = mk(0, 3'd1, 15'h1234, 8'h00, 0, 0, 8'h00, 1, -1, 0, 84, 1, 8'h6F);
      vecs[3] = mk(1, 3'd7, 15'h7FFF, 8'h3C, 10, 0, 8'h00, 0, -1, 0, 38, 0, 8'h6F);
      vecs[4] = mk(1, 3'd5, 15'h2AAA, 8'h81, 0, 0, 8'h00, 0, 12, 0, 15, 1, 8'h6F);
      vecs[5] = mk(0, 3'd4, 15'h0F0F, 8'h00, 0, 0, 8'hA3, 0, -1, 1, 30, 0, 8'hA3);
      vecs[6] = mk(0, 3'd6, 15'h4321, 8'h00, 0, 5, 8'h55, 0, 21, 0, 24, 1, 8'hA3);
      vecs[7] = mk(0, 3'd3, 15'h0001, 8'h00, 3, 2, 8'h81, 0, -1, 0, 34, 0, 8'h81);
      vecs[8] = mk(1, 3'd3, 15'h7001, 8'h5A, 0, 0, 8'h00, 0, -1, 0, 29, 0, 8'h00);

      rstn = 1'b1; start = 1'b0; rd_wrt_in = 1'b0; slave_id = '0; addr = '0; wr_data = '0;
      bus_grant = 1'b1; din = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("por");
      rstn = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Reset while SEND is on frame bit 5 (cycle 7 after start).
      start = 1'b1; rd_wrt_in = 1'b1; slave_id = 3'd6; addr = 15'h5555; wr_data = 8'hFF;
      bus_grant = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (n == 7) rstn = 1'b1;
      end
      @(negedge clk);
      check_reset("midrst");
      rstn = 1'b0;
      @(negedge clk);
      chk("midrst_no_frame", 32'({dout_en, dout, state}), 32'({1'b0, 1'b1, 3'd0}));

      run_vec(8, vecs[8]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end
endmodule
